// File: rtl/player_mover_if.sv
// Button, blocking-flag and player-state signals shared between the input side and player_mover.
interface player_mover_if #(
  parameter int N_RECT = 8
);
  logic [3:0]        btns;
  logic              btn_color;
  logic [N_RECT-1:0] up_block;
  logic [N_RECT-1:0] down_block;
  logic [N_RECT-1:0] left_block;
  logic [N_RECT-1:0] right_block;
  logic [9:0]        player_hPos;
  logic [9:0]        player_vPos;
  logic [3:0]        player_color;
  logic              moving;
  logic              bump;

  modport master (
    output btns, btn_color, up_block, down_block, left_block, right_block,
    input  player_hPos, player_vPos, player_color, moving, bump
  );

  modport slave (
    input  btns, btn_color, up_block, down_block, left_block, right_block,
    output player_hPos, player_vPos, player_color, moving, bump
  );
endinterface

// File: rtl/player_mover.sv
// Player sprite position/colour owner: tap-to-step and hold-to-repeat movement with
// edge clamping and per-rectangle blocking, plus a colour cycler on btn_color rising edges.
module player_mover #(
  parameter int N_RECT       = 8,
  parameter int PWIDTH       = 12,
  parameter int PHEIGHT      = 12,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int START_H      = 314,
  parameter int START_V      = 234,
  parameter int STEP         = 1,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 4
) (
  input logic btnClk,
  input logic rst,
  player_mover_if.slave bus
);
  localparam int CNT_W = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1;
  localparam logic [CNT_W-1:0] DELAY_T = CNT_W'(REPEAT_DELAY - 2);
  localparam logic [CNT_W-1:0] RATE_T  = CNT_W'(REPEAT_RATE - 2);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] PW_W   = 11'(PWIDTH);
  localparam logic [10:0] PH_W   = 11'(PHEIGHT);
  localparam logic [10:0] HRES_W = 11'(H_RES);
  localparam logic [10:0] VRES_W = 11'(V_RES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [3:0]        dir, dir_nxt;
  logic              rep, rep_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              step_go;
  logic [9:0]        h_pos, v_pos, h_new, v_new;
  logic [3:0]        color;
  logic              btn_color_q, bump_q;
  logic              blk, stuck;
  logic [N_RECT-1:0] up_v, down_v, left_v, right_v;

  assign up_v    = bus.up_block;
  assign down_v  = bus.down_block;
  assign left_v  = bus.left_block;
  assign right_v = bus.right_block;

  function automatic logic is_dir(input logic [3:0] code);
    return (code == 4'b1000) || (code == 4'b0100) || (code == 4'b0010) || (code == 4'b0001);
  endfunction

  function automatic logic [9:0] dec_sat(input logic [9:0] p);
    logic [10:0] p11;
    p11 = {1'b0, p};
    return (p11 >= STEP_W) ? 10'(p11 - STEP_W) : 10'd0;
  endfunction

  // Clamp so the far edge of the sprite never passes the screen limit.
  function automatic logic [9:0] inc_sat(input logic [9:0] p, input logic [10:0] size,
                                         input logic [10:0] lim);
    logic [10:0] p11;
    p11 = {1'b0, p};
    return (p11 + STEP_W + size <= lim) ? 10'(p11 + STEP_W) : 10'(lim - size);
  endfunction

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    rep_nxt   = rep;
    cnt_nxt   = cnt;
    step_go   = 1'b0;
    case (state)
      IDLE: begin
        if (is_dir(bus.btns)) begin
          step_go   = 1'b1;
          dir_nxt   = bus.btns;
          rep_nxt   = 1'b0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nxt   = '0;
        state_nxt = (bus.btns != dir) ? IDLE : HOLD;
      end
      HOLD: begin
        if (bus.btns != dir) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == (rep ? RATE_T : DELAY_T)) begin
            step_go   = 1'b1;
            rep_nxt   = 1'b1;
            state_nxt = SETTLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Whenever a step is issued the held code equals the latched direction, so btns selects it.
  always_comb begin
    h_new = h_pos;
    v_new = v_pos;
    blk   = 1'b0;
    case (bus.btns)
      4'b1000: begin blk = |up_v;    v_new = dec_sat(v_pos); end
      4'b0100: begin blk = |down_v;  v_new = inc_sat(v_pos, PH_W, VRES_W); end
      4'b0010: begin blk = |right_v; h_new = inc_sat(h_pos, PW_W, HRES_W); end
      4'b0001: begin blk = |left_v;  h_new = dec_sat(h_pos); end
      default: ;
    endcase
    stuck = blk || ((h_new == h_pos) && (v_new == v_pos));
  end

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dir   <= 4'd0;
      rep   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      rep   <= rep_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      h_pos       <= 10'(START_H);
      v_pos       <= 10'(START_V);
      color       <= 4'd0;
      btn_color_q <= 1'b0;
      bump_q      <= 1'b0;
    end else begin
      btn_color_q <= bus.btn_color;
      if (bus.btn_color && !btn_color_q) color <= color + 4'd1;
      bump_q <= step_go && stuck;
      if (step_go && !blk) begin
        h_pos <= h_new;
        v_pos <= v_new;
      end
    end
  end

  assign bus.player_hPos  = h_pos;
  assign bus.player_vPos  = v_pos;
  assign bus.player_color = color;
  assign bus.moving       = (state != IDLE);
  assign bus.bump         = bump_q;
endmodule
